// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated/propagated by this position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = x - y - bin) behind valid/ready handshakes.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   xs_q, xs_d;
  logic [WIDTH-1:0]   ys_q, ys_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic               bmsb_q, bmsb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               cell_d;
  logic               cell_bout;

  // The one arithmetic cell, fed by the low bits of the operand shifters
  full_subtractor u_cell (
    .a    (xs_q[0]),
    .b    (ys_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state, datapath shifting and output updates
  always_comb begin
    state_d     = state_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    res_d       = res_q;
    borrow_d    = borrow_q;
    bmsb_d      = bmsb_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          xs_d       = x;
          ys_d       = y;
          borrow_d   = bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        xs_d     = xs_q >> 1;
        ys_d     = ys_q >> 1;
        res_d    = (res_q >> 1) | {cell_d, {(WIDTH-1){1'b0}}};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        // Borrow out of bit WIDTH-2 is the borrow into the MSB
        if (cnt_q == CNT_W'(WIDTH - 2)) begin
          bmsb_d = cell_bout;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d      = res_d;
          bout_d      = cell_bout;
          ovf_d       = bmsb_q ^ cell_bout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xs_q        <= '0;
      ys_q        <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      bmsb_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      bmsb_q      <= bmsb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 4.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with out_ready held high: checks latency and result
  task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic bv, input logic [W-1:0] ed, input logic eb, input logic eo);
    check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    x = xv; y = yv; bin = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = ~xv; y = ~yv; bin = ~bv;
    check({tag, "_ready_after_accept"}, 32'(in_ready), 32'd0);
    for (int i = 1; i < int'(W); i++) begin
      check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      tick();
    end
    check({tag, "_valid_early_last"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    tick();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    bin       = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    run_op("v1", 4'b1001, 4'b1010, 1'b0, 4'b1111, 1'b1, 1'b0);
    run_op("v2", 4'b1111, 4'b1011, 1'b0, 4'b0100, 1'b0, 1'b0);
    run_op("v3", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
    run_op("v4", 4'b1000, 4'b0001, 1'b1, 4'b0110, 1'b0, 1'b1);
    run_op("v5", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);

    // Backpressure: op A = 5-3 held in DONE while op B = 6-1 is pending
    out_ready = 1'b0;
    x = 4'b0101; y = 4'b0011; bin = 1'b0; in_valid = 1'b1;
    tick();
    x = 4'b0110; y = 4'b0001; bin = 1'b0;
    check("bp_ready_run", 32'(in_ready), 32'd0);
    tick(); tick(); tick();
    check("bp_valid_early", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_diff", 32'(diff), 32'd2);
      check("bp_hold_bout", 32'(bout), 32'd0);
      check("bp_hold_ovf", 32'(ovf), 32'd0);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_pending_accepted", 32'(in_ready), 32'd0);
    tick(); tick(); tick();
    check("bp_b_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_diff", 32'(diff), 32'd5);
    check("bp_b_bout", 32'(bout), 32'd0);
    check("bp_b_ovf", 32'(ovf), 32'd0);
    tick();
    check("bp_b_done", 32'(out_valid), 32'd0);

    // Reset two cycles after accept aborts the operation
    x = 4'b1111; y = 4'b0000; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      check("post_rst_no_result", 32'(out_valid), 32'd0);
      check("post_rst_ready", 32'(in_ready), 32'd1);
    end

    // Recovery after reset
    run_op("v6", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
